// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_t       : E-stage operand mux select (register file / W result / M ALU result)
//   mem_state_t     : states of the multi-cycle data-memory stall FSM
//   RESULT_SRC_LOAD : ResultSrc encoding that marks a load in E
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of pipeline-status inputs and hazard-control outputs of hazard_unit.
//   slave  : the hazard unit (reads register indices/controls, drives selects/stalls/flushes/counters)
//   master : the pipeline or a testbench (drives status, observes controls)
interface hazard_unit_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH     = 32
) ();

    logic [ADDRESS_WIDTH-1:0] Rs1D_i;
    logic [ADDRESS_WIDTH-1:0] Rs2D_i;
    logic [ADDRESS_WIDTH-1:0] Rs1E_i;
    logic [ADDRESS_WIDTH-1:0] Rs2E_i;
    logic [ADDRESS_WIDTH-1:0] RdE_i;
    logic [ADDRESS_WIDTH-1:0] RdM_i;
    logic [ADDRESS_WIDTH-1:0] RdW_i;
    logic [1:0]               ResultSrcE_i;
    logic                     RegWriteM_i;
    logic                     RegWriteW_i;
    logic                     PCSrcE_i;
    logic                     MemAccessM_i;

    logic [1:0]               ForwardAE_o;
    logic [1:0]               ForwardBE_o;
    logic                     StallF_o;
    logic                     StallD_o;
    logic                     StallE_o;
    logic                     StallM_o;
    logic                     FlushD_o;
    logic                     FlushE_o;
    logic                     FlushW_o;
    logic [CNT_WIDTH-1:0]     StallCount_o;
    logic [CNT_WIDTH-1:0]     FlushCount_o;

    modport slave (
        input  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
               ResultSrcE_i, RegWriteM_i, RegWriteW_i, PCSrcE_i, MemAccessM_i,
        output ForwardAE_o, ForwardBE_o, StallF_o, StallD_o, StallE_o, StallM_o,
               FlushD_o, FlushE_o, FlushW_o, StallCount_o, FlushCount_o
    );

    modport master (
        output Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
               ResultSrcE_i, RegWriteM_i, RegWriteW_i, PCSrcE_i, MemAccessM_i,
        input  ForwardAE_o, ForwardBE_o, StallF_o, StallD_o, StallE_o, StallM_o,
               FlushD_o, FlushE_o, FlushW_o, StallCount_o, FlushCount_o
    );

endinterface

// File: rtl/hazard_unit_forward_sel.sv
// Forwarding select for one E-stage source operand.
//   rs_e_i                       : source register index in E
//   rd_m_i / reg_write_m_i       : destination and write enable of the instruction in M
//   rd_w_i / reg_write_w_i       : destination and write enable of the instruction in W
//   fwd_o                        : FWD_M, FWD_W or FWD_RF (never 2'b11)
module forward_sel
    import hazard_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic [ADDRESS_WIDTH-1:0] rs_e_i,
    input  logic [ADDRESS_WIDTH-1:0] rd_m_i,
    input  logic [ADDRESS_WIDTH-1:0] rd_w_i,
    input  logic                     reg_write_m_i,
    input  logic                     reg_write_w_i,
    output fwd_sel_t                 fwd_o
);

    // x0 is hard-wired to zero, so a write to it must never be forwarded.
    // M is checked first: it holds the younger, more recent value.
    always_comb begin
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
            fwd_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
            fwd_o = FWD_W;
        end else begin
            fwd_o = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I pipeline.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   hz (slave)   : register indices and controls from D/E/M/W in; forwarding selects,
//                  per-stage stall/flush controls and stall/flush event counters out
// A data-memory access holds M for MEM_LATENCY cycles (MEM_LATENCY-1 of them stalled);
// MEM_LATENCY must lie in 1..16.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int MEM_LATENCY   = 1,
    parameter int CNT_WIDTH     = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_unit_if.slave  hz
);

    mem_state_t           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                 mem_stall;
    logic                 lw_stall;
    fwd_sel_t             fwd_a, fwd_b;

    forward_sel #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_a (
        .rs_e_i        (hz.Rs1E_i),
        .rd_m_i        (hz.RdM_i),
        .rd_w_i        (hz.RdW_i),
        .reg_write_m_i (hz.RegWriteM_i),
        .reg_write_w_i (hz.RegWriteW_i),
        .fwd_o         (fwd_a)
    );

    forward_sel #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_b (
        .rs_e_i        (hz.Rs2E_i),
        .rd_m_i        (hz.RdM_i),
        .rd_w_i        (hz.RdW_i),
        .reg_write_m_i (hz.RegWriteM_i),
        .reg_write_w_i (hz.RegWriteW_i),
        .fwd_o         (fwd_b)
    );

    assign hz.ForwardAE_o = fwd_a;
    assign hz.ForwardBE_o = fwd_b;

    assign lw_stall = (hz.ResultSrcE_i == RESULT_SRC_LOAD) && (hz.RdE_i != '0) &&
                      ((hz.RdE_i == hz.Rs1D_i) || (hz.RdE_i == hz.Rs2D_i));

    // Memory FSM. The entry cycle already stalls, so cnt starts at MEM_LATENCY-2; the
    // cycle with cnt==0 in MEM_WAIT is the access's last cycle in M and is not stalled.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (hz.MemAccessM_i && (MEM_LATENCY > 1)) begin
                    mem_stall = 1'b1;
                    state_d   = MEM_WAIT;
                    cnt_d     = 4'(MEM_LATENCY - 2);
                end
            end
            MEM_WAIT: begin
                if (cnt_q != 4'd0) begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q - 4'd1;
                end else begin
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // Control priority: memory stall freezes everything (a taken branch in E waits in
    // the frozen stage), then branch flush, then load-use bubble.
    always_comb begin
        hz.StallF_o = 1'b0;
        hz.StallD_o = 1'b0;
        hz.StallE_o = 1'b0;
        hz.StallM_o = 1'b0;
        hz.FlushD_o = 1'b0;
        hz.FlushE_o = 1'b0;
        hz.FlushW_o = 1'b0;
        if (mem_stall) begin
            hz.StallF_o = 1'b1;
            hz.StallD_o = 1'b1;
            hz.StallE_o = 1'b1;
            hz.StallM_o = 1'b1;
            hz.FlushW_o = 1'b1;
        end else if (hz.PCSrcE_i) begin
            hz.FlushD_o = 1'b1;
            hz.FlushE_o = 1'b1;
        end else if (lw_stall) begin
            hz.StallF_o = 1'b1;
            hz.StallD_o = 1'b1;
            hz.FlushE_o = 1'b1;
        end
    end

    assign stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, hz.StallF_o};
    assign flush_cnt_d = flush_cnt_q + {{(CNT_WIDTH-1){1'b0}}, (hz.PCSrcE_i && !mem_stall)};

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= MEM_IDLE;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.StallCount_o = stall_cnt_q;
    assign hz.FlushCount_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized, scoreboarded bench for hazard_unit with MEM_LATENCY = 4.
module tb_hazard_unit;

    localparam int AW  = 5;
    localparam int LAT = 4;
    localparam int CW  = 32;

    typedef struct {
        logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0]    result_src_e;
        logic          reg_write_m, reg_write_w, pc_src_e, mem_access_m;
    } stim_t;

    typedef struct {
        logic [1:0]    fwd_a, fwd_b;
        logic          stall_f, stall_d, stall_e, stall_m;
        logic          flush_d, flush_e, flush_w;
        logic [CW-1:0] stall_cnt, flush_cnt;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    hazard_unit_if #(.ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) hz ();

    hazard_unit #(.ADDRESS_WIDTH(AW), .MEM_LATENCY(LAT), .CNT_WIDTH(CW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hz    (hz)
    );

    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t exp_q[$];

    // Reference model state: stall cycles still owed to the access in M, and whether
    // the access is in its final (released) cycle in M.
    int            m_stalls_left = 0;
    bit            m_release     = 1'b0;
    logic [CW-1:0] m_stall_cnt   = '0;
    logic [CW-1:0] m_flush_cnt   = '0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input stim_t s, input logic [AW-1:0] rs);
        if (s.reg_write_m && s.rdm != 0 && s.rdm == rs) return 2'b10;
        if (s.reg_write_w && s.rdw != 0 && s.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_stalls_left = 0;
        m_release     = 1'b0;
        m_stall_cnt   = '0;
        m_flush_cnt   = '0;
    endtask

    task automatic model_step(input stim_t s, output exp_t e);
        bit ms, lw;
        if (m_stalls_left == 0 && !m_release && s.mem_access_m && LAT > 1)
            m_stalls_left = LAT - 1;
        if (m_stalls_left > 0) begin
            ms = 1'b1;
            m_stalls_left--;
            if (m_stalls_left == 0) m_release = 1'b1;
        end else begin
            ms = 1'b0;
            m_release = 1'b0;
        end
        lw = (s.result_src_e == 2'b01) && (s.rde != 0) && (s.rde == s.rs1d || s.rde == s.rs2d);
        e.fwd_a   = ref_fwd(s, s.rs1e);
        e.fwd_b   = ref_fwd(s, s.rs2e);
        e.stall_f = ms || (!s.pc_src_e && lw);
        e.stall_d = e.stall_f;
        e.stall_e = ms;
        e.stall_m = ms;
        e.flush_w = ms;
        e.flush_d = !ms && s.pc_src_e;
        e.flush_e = !ms && (s.pc_src_e || lw);
        e.stall_cnt = m_stall_cnt;
        e.flush_cnt = m_flush_cnt;
        m_stall_cnt += CW'(e.stall_f);
        m_flush_cnt += CW'(!ms && s.pc_src_e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rs1d = '0; s.rs2d = '0; s.rs1e = '0; s.rs2e = '0;
        s.rde  = '0; s.rdm  = '0; s.rdw  = '0;
        s.result_src_e = 2'b00;
        s.reg_write_m = 1'b0; s.reg_write_w = 1'b0;
        s.pc_src_e = 1'b0; s.mem_access_m = 1'b0;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        hz.Rs1D_i = s.rs1d; hz.Rs2D_i = s.rs2d;
        hz.Rs1E_i = s.rs1e; hz.Rs2E_i = s.rs2e;
        hz.RdE_i  = s.rde;  hz.RdM_i  = s.rdm;  hz.RdW_i = s.rdw;
        hz.ResultSrcE_i = s.result_src_e;
        hz.RegWriteM_i  = s.reg_write_m;
        hz.RegWriteW_i  = s.reg_write_w;
        hz.PCSrcE_i     = s.pc_src_e;
        hz.MemAccessM_i = s.mem_access_m;
    endtask

    // Called just after a rising edge: applies one cycle of inputs, queues the expected
    // response, and returns just after the next rising edge.
    task automatic drive(input stim_t s);
        exp_t e;
        apply(s);
        model_step(s, e);
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge clk_i) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ForwardAE",  CW'(hz.ForwardAE_o), CW'(e.fwd_a));
            check("ForwardBE",  CW'(hz.ForwardBE_o), CW'(e.fwd_b));
            check("StallF",     CW'(hz.StallF_o),    CW'(e.stall_f));
            check("StallD",     CW'(hz.StallD_o),    CW'(e.stall_d));
            check("StallE",     CW'(hz.StallE_o),    CW'(e.stall_e));
            check("StallM",     CW'(hz.StallM_o),    CW'(e.stall_m));
            check("FlushD",     CW'(hz.FlushD_o),    CW'(e.flush_d));
            check("FlushE",     CW'(hz.FlushE_o),    CW'(e.flush_e));
            check("FlushW",     CW'(hz.FlushW_o),    CW'(e.flush_w));
            check("StallCount", hz.StallCount_o,     e.stall_cnt);
            check("FlushCount", hz.FlushCount_o,     e.flush_cnt);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ForwardAE"}, CW'(hz.ForwardAE_o), '0);
        check({tag, "_ForwardBE"}, CW'(hz.ForwardBE_o), '0);
        check({tag, "_Stalls"},  CW'({hz.StallF_o, hz.StallD_o, hz.StallE_o, hz.StallM_o}), '0);
        check({tag, "_Flushes"}, CW'({hz.FlushD_o, hz.FlushE_o, hz.FlushW_o}), '0);
        check({tag, "_StallCount"}, hz.StallCount_o, '0);
        check({tag, "_FlushCount"}, hz.FlushCount_o, '0);
    endtask

    initial begin
        stim_t s;
        apply(idle());
        #3;
        check_all_zero("reset");
        #4 rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Forwarding: M beats W; x0 in M falls back to W.
        s = idle();
        s.rdm = 5; s.reg_write_m = 1'b1; s.rdw = 5; s.reg_write_w = 1'b1;
        s.rs1e = 5; s.rs2e = 3;
        drive(s);
        s.rdm = 0;
        drive(s);

        // Load-use on rs2, then the same with rd = x0.
        s = idle(); s.result_src_e = 2'b01; s.rde = 7; s.rs2d = 7;
        drive(s);
        drive(idle());
        s.rde = 0;
        drive(s);

        // Taken branch together with a load-use hazard.
        s = idle(); s.result_src_e = 2'b01; s.rde = 9; s.rs1d = 9; s.pc_src_e = 1'b1;
        drive(s);
        drive(idle());

        // Two back-to-back accesses with MemAccessM held high.
        s = idle(); s.mem_access_m = 1'b1;
        repeat (2 * LAT) drive(s);
        drive(idle());

        // Branch resolved while M is frozen: flush only on the release cycle.
        s = idle(); s.mem_access_m = 1'b1; s.pc_src_e = 1'b1;
        drive(s);
        s.mem_access_m = 1'b0;
        repeat (LAT - 1) drive(s);
        drive(idle());

        // Asynchronous reset in the middle of a memory stall.
        s = idle(); s.mem_access_m = 1'b1;
        drive(s);
        apply(idle());
        #1;
        check("stall_before_rst", CW'(hz.StallF_o), CW'(1));
        rst_i = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk_i);
        #1 rst_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        s = idle(); s.mem_access_m = 1'b1;
        repeat (LAT) drive(s);
        drive(idle());

        // Randomized traffic over a small register range to provoke many matches.
        for (int i = 0; i < 400; i++) begin
            s.rs1d = AW'($urandom_range(0, 3));
            s.rs2d = AW'($urandom_range(0, 3));
            s.rs1e = AW'($urandom_range(0, 3));
            s.rs2e = AW'($urandom_range(0, 3));
            s.rde  = AW'($urandom_range(0, 3));
            s.rdm  = AW'($urandom_range(0, 3));
            s.rdw  = AW'($urandom_range(0, 3));
            s.result_src_e = 2'($urandom_range(0, 3));
            s.reg_write_m  = 1'($urandom_range(0, 1));
            s.reg_write_w  = 1'($urandom_range(0, 1));
            s.pc_src_e     = ($urandom_range(0, 5) == 0);
            s.mem_access_m = ($urandom_range(0, 7) == 0);
            drive(s);
        end
        apply(idle());

        repeat (3) @(posedge clk_i);
        check("queue_drained", CW'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Hazard controller for the 5-stage pipelined RV32I core. It produces the operand-forwarding selects for the E-stage muxes, the load-use stall, the branch/jump flush, and a multi-cycle data-memory stall sized by MEM_LATENCY. A free-running stall/flush event counter pair supports performance measurement. It replaces the tied-off en/clr/Forward signals in top and drives pc_reg en, the pip_reg_d/e/m/w enables and clears, and the SrcAE/WriteDataE muxes.

Parameters:
ADDRESS_WIDTH, 5, register index width
MEM_LATENCY, 1, cycles a load/store occupies M (1 = single-cycle memory, no memory stall); legal range 1..16
CNT_WIDTH, 32, width of performance counters

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
Rs1D_i  in  ADDRESS_WIDTH  rs1 index in D
Rs2D_i  in  ADDRESS_WIDTH  rs2 index in D
Rs1E_i  in  ADDRESS_WIDTH  rs1 index in E
Rs2E_i  in  ADDRESS_WIDTH  rs2 index in E
RdE_i  in  ADDRESS_WIDTH  rd in E
RdM_i  in  ADDRESS_WIDTH  rd in M
RdW_i  in  ADDRESS_WIDTH  rd in W
ResultSrcE_i  in  2  result select in E (2'b01 = load)
RegWriteM_i  in  1  register write in M
RegWriteW_i  in  1  register write in W
PCSrcE_i  in  1  taken branch/jump resolved in E
MemAccessM_i  in  1  load or store valid in M
ForwardAE_o  out  2  SrcA select: 00 RD1E, 01 ResultW, 10 ALUResultM
ForwardBE_o  out  2  WriteData select, same encoding
StallF_o  out  1  hold PC (pc_reg en = ~StallF_o)
StallD_o  out  1  hold D register
StallE_o  out  1  hold E register
StallM_o  out  1  hold M register
FlushD_o  out  1  clear D register
FlushE_o  out  1  clear E register
FlushW_o  out  1  insert bubble into W
StallCount_o  out  CNT_WIDTH  cycles with StallF_o high
FlushCount_o  out  CNT_WIDTH  cycles with PCSrcE_i honoured

Behaviour:
- Forwarding (combinational, per operand): if RegWriteM_i && RdM_i!=0 && RdM_i==Rs1E_i -> 10; else if RegWriteW_i && RdW_i!=0 && RdW_i==Rs1E_i -> 01; else 00. Same for B with Rs2E_i. M beats W. 11 is never produced.
- Load-use (lw_stall): ResultSrcE_i==01 && RdE_i!=0 && (RdE_i==Rs1D_i || RdE_i==Rs2D_i).
- Memory FSM, states MEM_IDLE and MEM_WAIT, 4-bit down-counter cnt:
  - MEM_IDLE: if MemAccessM_i && MEM_LATENCY>1, assert mem_stall, go to MEM_WAIT, cnt <= MEM_LATENCY-2.
  - MEM_WAIT: mem_stall = (cnt!=0). Decrement while nonzero. At cnt==0, deassert and return to MEM_IDLE (the instruction leaves M on that edge and is not retriggered).
  - Result: each access spends exactly MEM_LATENCY cycles in M, with MEM_LATENCY-1 stall cycles. With MEM_LATENCY==1 the FSM never leaves MEM_IDLE.
- Priority, highest first:
  - mem_stall: StallF, StallD, StallE, StallM = 1; FlushW = 1; FlushD, FlushE = 0. A pending PCSrcE_i is held in frozen E and honoured after release.
  - PCSrcE_i: FlushD = FlushE = 1; StallF = StallD = 0, even if lw_stall is also true.
  - lw_stall: StallF = StallD = 1; FlushE = 1.
  - Otherwise all control outputs are 0.
- Counters: StallCount_o increments every cycle StallF_o==1. FlushCount_o increments every cycle PCSrcE_i && !mem_stall. Both wrap modulo 2^CNT_WIDTH.
- Reset (asynchronous, any state including mid-MEM_WAIT): state MEM_IDLE, cnt 0, both counters 0. Stall and flush outputs depend only on the reset-state FSM plus inputs, so with idle inputs every output is 0.

Decomposition:
- hazard_pkg: fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10), mem_state_t enum (MEM_IDLE, MEM_WAIT), RESULT_SRC_LOAD=2'b01.
- One sub-module, forward_sel: combinational M/W priority compare, instantiated twice (A and B).

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=3 -> ForwardAE=10, ForwardBE=00. Repeat with RdM=0 -> ForwardAE=01.
- ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, StallCount 0->1. Repeat with RdE=0 -> no stall.
- PCSrcE=1 together with the load-use condition -> FlushD=FlushE=1, StallF=0, FlushCount increments.
- MEM_LATENCY=4, MemAccessM pulse held -> StallF/D/E/M and FlushW high for exactly 3 cycles, then 0; MemAccessM held high afterwards (next access) -> new 3-cycle stall.
- MEM_LATENCY=4, PCSrcE=1 during memory stall -> no flush while stalled; FlushD=FlushE=1 on the release cycle.
- Assert rst_i asynchronously mid-MEM_WAIT -> all outputs 0 immediately, counters 0, next access stalls a full 3 cycles.
